// File: rtl/note_divider_if.sv
// ============================================================================
// Module      : note_divider_if
// Description : Control and status bundle for the note_divider tone generator.
//               Carries the octave select only when NOTE_DIVIDER_OCTAVE_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface note_divider_if #(
  parameter int CNT_W = 12
);
  logic             en;
  logic [3:0]       note;
`ifdef NOTE_DIVIDER_OCTAVE_EN
  logic [1:0]       octave;
`endif
  logic             tone;
  logic             clr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       note_q;
  logic             active;

  // Controller side: drives requests, observes the generator.
  modport master (
    output en,
    output note,
`ifdef NOTE_DIVIDER_OCTAVE_EN
    output octave,
`endif
    input  tone,
    input  clr,
    input  cnt,
    input  note_q,
    input  active
  );

  // Generator side.
  modport slave (
    input  en,
    input  note,
`ifdef NOTE_DIVIDER_OCTAVE_EN
    input  octave,
`endif
    output tone,
    output clr,
    output cnt,
    output note_q,
    output active
  );
endinterface

`default_nettype wire

// File: rtl/note_divider.sv
// ============================================================================
// Module      : note_divider
// Description : Square-wave note generator. A period counter runs to a
//               per-note terminal value and toggles the tone output on each
//               terminal count. Note changes between playing codes are
//               deferred to the half-period boundary; pause codes act at once.
//               Optional macro NOTE_DIVIDER_OCTAVE_EN adds an octave select
//               that divides the half-period by 2^octave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_divider #(
  parameter int   CNT_W     = 12,
  parameter logic PAUSE_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  note_divider_if.slave bus
);

  logic [CNT_W-1:0] cnt;
  logic             tone;
  logic             clr;
  logic [3:0]       note_q;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] term;
  logic             active;
  logic             note_play;
  logic             note_new;
`ifdef NOTE_DIVIDER_OCTAVE_EN
  logic [1:0]       octave_q;
`endif

  function automatic logic is_play(input logic [3:0] code);
    return (code != 4'd0) && (code <= 4'd8);
  endfunction

  assign active    = is_play(note_q);
  assign note_play = is_play(bus.note);
  assign note_new  = (bus.note != note_q);

  // Base half-period terminal value for the note currently playing.
  always_comb begin
    base = '0;
    case (note_q)
      4'd1:    base = CNT_W'(10'd956);
      4'd2:    base = CNT_W'(10'd851);
      4'd3:    base = CNT_W'(10'd758);
      4'd4:    base = CNT_W'(10'd716);
      4'd5:    base = CNT_W'(10'd638);
      4'd6:    base = CNT_W'(10'd568);
      4'd7:    base = CNT_W'(10'd506);
      4'd8:    base = CNT_W'(10'd478);
      default: base = '0;
    endcase
  end

  // Terminal value: half-period length P+1 is divided by 2^octave when enabled.
`ifdef NOTE_DIVIDER_OCTAVE_EN
  always_comb begin
    term = ((base + CNT_W'(1)) >> octave_q) - CNT_W'(1);
  end
`else
  always_comb begin
    term = base;
  end
`endif

  // Counter, tone, note latch and terminal pulse; pauses act immediately,
  // playing-note changes only at the half-period boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      tone     <= PAUSE_LVL;
      clr      <= 1'b0;
      note_q   <= 4'd0;
`ifdef NOTE_DIVIDER_OCTAVE_EN
      octave_q <= 2'd0;
`endif
    end else begin
      clr <= 1'b0;
      if (bus.en) begin
        if (!note_play && note_new) begin
          note_q   <= bus.note;
`ifdef NOTE_DIVIDER_OCTAVE_EN
          octave_q <= bus.octave;
`endif
          cnt      <= '0;
          tone     <= PAUSE_LVL;
        end else if (!active) begin
          if (note_play) begin
            note_q   <= bus.note;
`ifdef NOTE_DIVIDER_OCTAVE_EN
            octave_q <= bus.octave;
`endif
            cnt      <= '0;
            tone     <= PAUSE_LVL;
          end
        end else if (cnt == term) begin
          cnt      <= '0;
          tone     <= ~tone;
          clr      <= 1'b1;
          note_q   <= bus.note;
`ifdef NOTE_DIVIDER_OCTAVE_EN
          octave_q <= bus.octave;
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.cnt    = cnt;
  assign bus.tone   = tone;
  assign bus.clr    = clr;
  assign bus.note_q = note_q;
  assign bus.active = active;

endmodule

`default_nettype wire
